// File: rtl/ad7478_scan_scheduler.sv
// Round-robin scheduler sharing one AD7478 driver (behind an analog mux) among N_REQ requesters.
// Grants, settles the mux, starts one conversion and returns the 8-bit result with a one-hot ack.
module ad7478_scan_scheduler #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned CHAN_W      = 3,
  parameter int unsigned SETTLE_CYC  = 50,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*CHAN_W-1:0]   req_chan,
  output logic [N_REQ-1:0]          ack,
  output logic [7:0]                rsp_data,
  output logic [CHAN_W-1:0]         rsp_chan,
  output logic                      rsp_err,
  output logic                      sched_busy,
  output logic [CHAN_W-1:0]         mux_sel,
  output logic                      adc_start,
  input  logic                      adc_busy,
  input  logic                      adc_done,
  input  logic [7:0]                adc_data
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_e;

  state_e             state_q,    state_d;
  logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q,      gnt_d;
  logic [CHAN_W-1:0]  mux_sel_q,  mux_sel_d;
  logic               settled_q,  settled_d;
  logic [SET_W-1:0]   set_cnt_q,  set_cnt_d;
  logic [TO_W-1:0]    to_cnt_q,   to_cnt_d;
  logic [7:0]         rsp_data_q, rsp_data_d;
  logic [CHAN_W-1:0]  rsp_chan_q, rsp_chan_d;
  logic               rsp_err_q,  rsp_err_d;
  logic [N_REQ-1:0]   ack_q,      ack_d;
  logic               start_q,    start_d;

  logic [CHAN_W-1:0]  chan_arr [N_REQ];
  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  int unsigned        arb_k;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chan
    assign chan_arr[gi] = req_chan[gi*CHAN_W +: CHAN_W];
  end

  // First requester at or after rr_ptr, wrapping around
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_k     = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      arb_k = (32'(rr_ptr_q) + i) % N_REQ;
      if (!arb_found && req[IDX_W'(arb_k)]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(arb_k);
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      mux_sel_q  <= '0;
      settled_q  <= 1'b0;
      set_cnt_q  <= '0;
      to_cnt_q   <= '0;
      rsp_data_q <= '0;
      rsp_chan_q <= '0;
      rsp_err_q  <= 1'b0;
      ack_q      <= '0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      mux_sel_q  <= mux_sel_d;
      settled_q  <= settled_d;
      set_cnt_q  <= set_cnt_d;
      to_cnt_q   <= to_cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_chan_q <= rsp_chan_d;
      rsp_err_q  <= rsp_err_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = gnt_q;
    mux_sel_d  = mux_sel_q;
    settled_d  = settled_q;
    set_cnt_d  = set_cnt_q;
    to_cnt_d   = to_cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_chan_d = rsp_chan_q;
    rsp_err_d  = rsp_err_q;
    ack_d      = '0;
    start_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          gnt_d     = arb_idx;
          mux_sel_d = chan_arr[arb_idx];
          rr_ptr_d  = (arb_idx == IDX_LAST) ? '0 : arb_idx + 1'b1;
          set_cnt_d = '0;
          // Mux already parked on this channel after a good conversion: no settle needed
          if (settled_q && (chan_arr[arb_idx] == mux_sel_q)) begin
            state_d = S_START;
          end else begin
            state_d = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (set_cnt_q == SET_LAST) begin
          state_d = S_START;
        end else begin
          set_cnt_d = set_cnt_q + 1'b1;
        end
      end
      S_START: begin
        if (!adc_busy) begin
          start_d  = 1'b1;
          to_cnt_d = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // adc_done takes priority over a timeout expiring on the same edge
        if (adc_done) begin
          rsp_data_d = adc_data;
          rsp_chan_d = mux_sel_q;
          rsp_err_d  = 1'b0;
          settled_d  = 1'b1;
          state_d    = S_RESP;
        end else if (to_cnt_q == TO_LAST) begin
          rsp_data_d = '0;
          rsp_chan_d = mux_sel_q;
          rsp_err_d  = 1'b1;
          settled_d  = 1'b0;
          state_d    = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        ack_d[gnt_q] = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ack        = ack_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_chan   = rsp_chan_q;
  assign rsp_err    = rsp_err_q;
  assign mux_sel    = mux_sel_q;
  assign adc_start  = start_q;
  assign sched_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_ad7478_scan_scheduler.sv
// Directed bench for ad7478_scan_scheduler: reset, latency, round-robin order, settle skip,
// busy hold-off, timeout and done/timeout collision.
module tb_ad7478_scan_scheduler;

  logic        sclk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] req_chan;
  logic [3:0]  ack;
  logic [7:0]  rsp_data;
  logic [2:0]  rsp_chan;
  logic        rsp_err;
  logic        sched_busy;
  logic [2:0]  mux_sel;
  logic        adc_start;
  logic        adc_busy;
  logic        adc_done;
  logic [7:0]  adc_data;

  int checks = 0;
  int errors = 0;

  ad7478_scan_scheduler #(
    .N_REQ      (4),
    .CHAN_W     (3),
    .SETTLE_CYC (50),
    .TIMEOUT_CYC(1000)
  ) dut (
    .sclk      (sclk),
    .rst       (rst),
    .req       (req),
    .req_chan  (req_chan),
    .ack       (ack),
    .rsp_data  (rsp_data),
    .rsp_chan  (rsp_chan),
    .rsp_err   (rsp_err),
    .sched_busy(sched_busy),
    .mux_sel   (mux_sel),
    .adc_start (adc_start),
    .adc_busy  (adc_busy),
    .adc_done  (adc_done),
    .adc_data  (adc_data)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge sclk);
    #1;
  endtask

  // Ticks until adc_start is seen; n = ticks taken
  task automatic wait_start(input int limit, output int n);
    n = 0;
    while (!adc_start && n < limit) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ack(input int limit, output int n, output logic [3:0] a);
    n = 0;
    do begin
      tick();
      n++;
    end while (ack == 4'b0 && n < limit);
    a = ack;
  endtask

  // Called right after adc_start is observed: driver answers on the next edge
  task automatic answer(input logic [7:0] d, output int n, output logic [3:0] a);
    adc_done = 1'b1;
    adc_data = d;
    tick();
    adc_done = 1'b0;
    wait_ack(20, n, a);
  endtask

  task automatic test_reset;
    int n;
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({ack, rsp_data, rsp_chan, rsp_err, sched_busy, mux_sel, adc_start} !== '0)
      begin errors++; $display("FAIL reset_outputs: got %h expected 0",
        {ack, rsp_data, rsp_chan, rsp_err, sched_busy, mux_sel, adc_start}); end
    rst = 1'b0;
    req_chan[0 +: 3] = 3'd2;
    req = 4'b0001;
    wait_start(200, n);
    checks++;
    if (n !== 52) begin errors++; $display("FAIL reset_pre_start: got %0d expected 52", n); end
    repeat (5) tick();
    checks++;
    if (sched_busy !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b expected 1", sched_busy); end
    rst = 1'b1;
    tick();
    checks++;
    if ({ack, rsp_data, rsp_chan, rsp_err, sched_busy, mux_sel, adc_start} !== '0)
      begin errors++; $display("FAIL reset_midwait: got %h expected 0",
        {ack, rsp_data, rsp_chan, rsp_err, sched_busy, mux_sel, adc_start}); end
    tick();
    tick();
    checks++;
    if ({ack, adc_start, sched_busy} !== 6'b0)
      begin errors++; $display("FAIL reset_hold: got %b expected 0", {ack, adc_start, sched_busy}); end
    req = 4'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin;
    int n;
    logic [3:0] a;
    logic [3:0] exp_ack [5];
    exp_ack = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int unsigned i = 0; i < 4; i++) req_chan[i*3 +: 3] = 3'(i + 1);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(200, n);
      checks++;
      if (n !== 52) begin errors++; $display("FAIL rr_start_lat[%0d]: got %0d expected 52", k, n); end
      answer(8'h10 + 8'(k), n, a);
      checks++;
      if (a !== exp_ack[k]) begin errors++; $display("FAIL rr_ack[%0d]: got %b expected %b", k, a, exp_ack[k]); end
      checks++;
      if (rsp_data !== 8'h10 + 8'(k)) begin errors++; $display("FAIL rr_data[%0d]: got %h expected %h", k, rsp_data, 8'h10 + 8'(k)); end
      if (k == 4) req = 4'b0;
    end
    tick();
    checks++;
    if (sched_busy !== 1'b0) begin errors++; $display("FAIL rr_idle_after: got %b expected 0", sched_busy); end
  endtask

  task automatic test_single;
    int n;
    logic [3:0] a;
    req_chan = '0;
    req_chan[6 +: 3] = 3'd5;
    req = 4'b0100;
    tick();
    checks++;
    if (mux_sel !== 3'd5 || sched_busy !== 1'b1)
      begin errors++; $display("FAIL single_grant: got mux %0d busy %b expected mux 5 busy 1", mux_sel, sched_busy); end
    req_chan[6 +: 3] = 3'd1;
    wait_start(200, n);
    checks++;
    if (n !== 51) begin errors++; $display("FAIL single_start_lat: got %0d expected 51", n); end
    answer(8'hA7, n, a);
    checks++;
    if (n !== 1) begin errors++; $display("FAIL single_ack_lat: got %0d expected 1", n); end
    checks++;
    if ({a, rsp_data, rsp_chan, rsp_err} !== {4'b0100, 8'hA7, 3'd5, 1'b0})
      begin errors++; $display("FAIL single_rsp: got ack %b data %h chan %0d err %b expected 0100 a7 5 0",
        a, rsp_data, rsp_chan, rsp_err); end
    req = 4'b0;
    tick();
    checks++;
    if (ack !== 4'b0 || rsp_data !== 8'hA7)
      begin errors++; $display("FAIL single_after: got ack %b data %h expected 0000 a7", ack, rsp_data); end
  endtask

  task automatic test_same_chan;
    int n;
    logic [3:0] a;
    req_chan = '0;
    req_chan[3 +: 3] = 3'd5;
    req = 4'b0010;
    wait_start(200, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL skip_start_lat: got %0d expected 2", n); end
    answer(8'h3C, n, a);
    checks++;
    if ({a, rsp_data, rsp_chan} !== {4'b0010, 8'h3C, 3'd5})
      begin errors++; $display("FAIL skip_rsp: got ack %b data %h chan %0d expected 0010 3c 5", a, rsp_data, rsp_chan); end
    req = 4'b0;
    tick();
  endtask

  task automatic test_busy_timeout;
    int n;
    logic [3:0] a;
    logic seen;
    req_chan = '0;
    req_chan[9 +: 3] = 3'd6;
    req = 4'b1000;
    adc_busy = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 71; i++) begin
      tick();
      if (adc_start) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || sched_busy !== 1'b1)
      begin errors++; $display("FAIL busy_hold: got start %b busy %b expected 0 1", seen, sched_busy); end
    adc_busy = 1'b0;
    tick();
    checks++;
    if (adc_start !== 1'b1) begin errors++; $display("FAIL busy_release_start: got %b expected 1", adc_start); end
    req = 4'b0;
    wait_ack(1100, n, a);
    checks++;
    if (n !== 1001) begin errors++; $display("FAIL timeout_lat: got %0d expected 1001", n); end
    checks++;
    if ({a, rsp_data, rsp_chan, rsp_err} !== {4'b1000, 8'h00, 3'd6, 1'b1})
      begin errors++; $display("FAIL timeout_rsp: got ack %b data %h chan %0d err %b expected 1000 00 6 1",
        a, rsp_data, rsp_chan, rsp_err); end
    tick();
  endtask

  task automatic test_collision;
    int n;
    logic [3:0] a;
    req_chan = '0;
    req_chan[0 +: 3] = 3'd6;
    req = 4'b0001;
    wait_start(200, n);
    checks++;
    if (n !== 52) begin errors++; $display("FAIL coll_start_lat: got %0d expected 52", n); end
    req = 4'b0;
    repeat (999) tick();
    adc_done = 1'b1;
    adc_data = 8'h5A;
    tick();
    adc_done = 1'b0;
    checks++;
    if (ack !== 4'b0) begin errors++; $display("FAIL coll_early_ack: got %b expected 0000", ack); end
    tick();
    checks++;
    if ({ack, rsp_data, rsp_err} !== {4'b0001, 8'h5A, 1'b0})
      begin errors++; $display("FAIL coll_rsp: got ack %b data %h err %b expected 0001 5a 0", ack, rsp_data, rsp_err); end
    repeat (3) tick();
    adc_done = 1'b1;
    adc_data = 8'hEE;
    tick();
    adc_done = 1'b0;
    seen_ack_check();
  endtask

  task automatic seen_ack_check;
    logic [3:0] acc;
    logic busy_seen;
    acc = '0;
    busy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      acc = acc | ack;
      busy_seen = busy_seen | sched_busy | adc_start;
    end
    checks++;
    if (acc !== 4'b0 || busy_seen !== 1'b0 || rsp_data !== 8'h5A)
      begin errors++; $display("FAIL idle_done_ignored: got ack %b busy %b data %h expected 0000 0 5a",
        acc, busy_seen, rsp_data); end
  endtask

  initial begin
    rst      = 1'b1;
    req      = '0;
    req_chan = '0;
    adc_busy = 1'b0;
    adc_done = 1'b0;
    adc_data = '0;
    test_reset();
    test_round_robin();
    test_single();
    test_same_chan();
    test_busy_timeout();
    test_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
